// File: rtl/eth_tx_sched.sv
// Frame scheduler sharing one TX builder between ARP replies and UDP frames; optional stats via ETH_TX_SCHED_STATS_EN.
// Latency: request seen in IDLE at cycle N gives tx_start at N+1; tx_start spacing >= 2 + frame + IFG_CYCLES.
// Backpressure: udp_req is a level re-sampled in IDLE only; ARP requests are latched one deep, newer overwrites older.
module eth_tx_sched #(
    parameter int IFG_CYCLES     = 12,
    parameter int MAX_ARP_BURST  = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              arp_req,
    input  logic [47:0]       arp_req_mac,
    input  logic              udp_req,
    input  logic              tx_done,
    output logic              tx_start,
    output logic              tx_sel,
    output logic [47:0]       tx_mac_d_addr,
    output logic              tx_busy,
    output logic              tx_abort,
    output logic              arp_pending
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]  arp_tx_cnt,
    output logic [CNT_W-1:0]  udp_tx_cnt,
    output logic [CNT_W-1:0]  arp_drop_cnt,
    output logic [CNT_W-1:0]  abort_cnt
`endif
);

    localparam int TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam int IFG_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int BURST_W = $clog2(MAX_ARP_BURST + 1);

    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IFG_W-1:0]   IFG_LAST  = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_ARP_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_IFG
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TO_W-1:0]      to_cnt;
    logic [IFG_W-1:0]     ifg_cnt;
    logic [BURST_W-1:0]   burst_cnt;
    logic [47:0]          pend_mac;
    logic                 grant_arp;
    logic                 grant_udp;
    logic                 timeout_hit;

    always_comb begin
        state_nxt   = state;
        grant_arp   = 1'b0;
        grant_udp   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                // UDP only overtakes a pending ARP once the burst allowance is used up
                if (arp_pending && !(udp_req && burst_cnt == BURST_MAX)) begin
                    grant_arp = 1'b1;
                end else if (udp_req) begin
                    grant_udp = 1'b1;
                end
                if (grant_arp || grant_udp) begin
                    state_nxt = S_START;
                end
            end
            S_START: state_nxt = S_BUSY;
            S_BUSY: begin
                if (tx_done || to_cnt == TO_LAST) begin
                    timeout_hit = !tx_done;
                    state_nxt   = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
                end
            end
            S_IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            to_cnt        <= '0;
            ifg_cnt       <= '0;
            burst_cnt     <= '0;
            pend_mac      <= '0;
            arp_pending   <= 1'b0;
            tx_sel        <= 1'b0;
            tx_mac_d_addr <= '0;
            tx_abort      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_abort <= timeout_hit;
            to_cnt   <= (state == S_BUSY) ? to_cnt + 1'b1 : '0;
            ifg_cnt  <= (state == S_IFG) ? ifg_cnt + 1'b1 : '0;

            if (grant_arp || grant_udp) begin
                tx_sel        <= grant_arp;
                tx_mac_d_addr <= grant_arp ? pend_mac : '0;
            end else if (state_nxt == S_IDLE) begin
                tx_sel        <= 1'b0;
                tx_mac_d_addr <= '0;
            end

            // a new request in the grant cycle keeps the latch armed with the new MAC
            if (arp_req) begin
                arp_pending <= 1'b1;
                pend_mac    <= arp_req_mac;
            end else if (grant_arp) begin
                arp_pending <= 1'b0;
            end

            if (grant_udp) begin
                burst_cnt <= '0;
            end else if (grant_arp) begin
                if (!udp_req) begin
                    burst_cnt <= BURST_W'(1);
                end else if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ETH_TX_SCHED_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            arp_tx_cnt   <= '0;
            udp_tx_cnt   <= '0;
            arp_drop_cnt <= '0;
            abort_cnt    <= '0;
        end else begin
            if (grant_arp && arp_tx_cnt != '1) begin
                arp_tx_cnt <= arp_tx_cnt + 1'b1;
            end
            if (grant_udp && udp_tx_cnt != '1) begin
                udp_tx_cnt <= udp_tx_cnt + 1'b1;
            end
            if (arp_req && arp_pending && !grant_arp && arp_drop_cnt != '1) begin
                arp_drop_cnt <= arp_drop_cnt + 1'b1;
            end
            if (timeout_hit && abort_cnt != '1) begin
                abort_cnt <= abort_cnt + 1'b1;
            end
        end
    end
`endif

    assign tx_start = (state == S_START);
    assign tx_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: directed scenarios then random traffic, checked every cycle against a
// frame-window model (start / last-busy / idle cycles computed arithmetically per grant).
module tb_eth_tx_sched;

    localparam int IFG   = 12;
    localparam int BURST = 4;
    localparam int TO    = 64;

    logic        aclk = 1'b0;
    logic        areset;
    logic        arp_req;
    logic [47:0] arp_req_mac;
    logic        udp_req;
    logic        tx_done;
    logic        tx_start;
    logic        tx_sel;
    logic [47:0] tx_mac_d_addr;
    logic        tx_busy;
    logic        tx_abort;
    logic        arp_pending;
`ifdef ETH_TX_SCHED_STATS_EN
    logic [15:0] arp_tx_cnt, udp_tx_cnt, arp_drop_cnt, abort_cnt;
`endif

    eth_tx_sched #(
        .IFG_CYCLES(IFG), .MAX_ARP_BURST(BURST), .TIMEOUT_CYCLES(TO), .CNT_W(16)
    ) dut (
        .aclk(aclk), .areset(areset), .arp_req(arp_req), .arp_req_mac(arp_req_mac),
        .udp_req(udp_req), .tx_done(tx_done), .tx_start(tx_start), .tx_sel(tx_sel),
        .tx_mac_d_addr(tx_mac_d_addr), .tx_busy(tx_busy), .tx_abort(tx_abort),
        .arp_pending(arp_pending)
`ifdef ETH_TX_SCHED_STATS_EN
        , .arp_tx_cnt(arp_tx_cnt), .udp_tx_cnt(udp_tx_cnt),
        .arp_drop_cnt(arp_drop_cnt), .abort_cnt(abort_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    // stimulus intent for the current cycle
    bit          d_rst, d_arp, d_udp, rnd_len, spur;
    logic [47:0] d_mac;
    int          next_len;

    // reference model: request latch plus the time windows of the frame in flight
    bit          m_pend, m_sel;
    logic [47:0] m_mac, m_fmac;
    int          m_burst, m_start, m_last, m_idle, m_abort, m_done;
    int          m_arp_tx, m_udp_tx, m_drop, m_abn;

    bit          obs_q[$];
    logic [47:0] last_mac;
    int          start_obs, abort_gap, n_abort_obs;
    bit          pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pick_len();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return TO - 1;
        return int'($urandom_range(1, 20));
    endfunction

    task automatic model_edge();
        bit idle, ga, gu;
        int len;
        if (d_rst) begin
            m_pend = 0; m_burst = 0; m_sel = 0; m_fmac = '0; m_mac = '0;
            m_start = -100; m_last = -100; m_abort = -100; m_done = -100;
            m_idle = cyc + 1;
            m_arp_tx = 0; m_udp_tx = 0; m_drop = 0; m_abn = 0;
            return;
        end
        idle = (cyc >= m_idle);
        ga   = idle && m_pend && !(d_udp && m_burst == BURST);
        gu   = idle && !ga && d_udp;
        if (ga || gu) begin
            len     = rnd_len ? pick_len() : next_len;
            m_start = cyc + 1;
            m_sel   = ga;
            m_fmac  = ga ? m_mac : 48'h0;
            if (len >= 1 && len <= TO) begin
                m_last  = m_start + len;
                m_done  = m_last;
                m_abort = -100;
            end else begin
                m_last  = m_start + TO;
                m_done  = -100;
                m_abort = m_last + 1;
            end
            m_idle = m_last + IFG + 1;
            if (ga) begin
                m_arp_tx++;
                m_burst = d_udp ? ((m_burst < BURST) ? m_burst + 1 : BURST) : 1;
            end else begin
                m_udp_tx++;
                m_burst = 0;
            end
        end
        if (d_arp) begin
            if (m_pend && !ga) m_drop++;
            m_pend = 1;
            m_mac  = d_mac;
        end else if (ga) begin
            m_pend = 0;
        end
    endtask

    task automatic step();
        bit in_busy, exp_busy;
        in_busy     = (cyc > m_start) && (cyc <= m_last);
        areset      = d_rst;
        arp_req     = d_arp;
        arp_req_mac = d_mac;
        udp_req     = d_udp;
        tx_done     = (cyc == m_done) || (spur && !in_busy && $urandom_range(0, 5) == 0);
        model_edge();
        @(posedge aclk);
        #1;
        cyc++;
        if (cyc == m_abort) m_abn++;
        exp_busy = (cyc >= m_start) && (cyc < m_idle);
        chk("tx_start", 64'(tx_start), 64'(cyc == m_start));
        chk("tx_busy", 64'(tx_busy), 64'(exp_busy));
        chk("tx_abort", 64'(tx_abort), 64'(cyc == m_abort));
        chk("tx_sel", 64'(tx_sel), 64'(exp_busy ? m_sel : 1'b0));
        chk("tx_mac", 64'(tx_mac_d_addr), 64'(exp_busy ? m_fmac : 48'h0));
        chk("arp_pending", 64'(arp_pending), 64'(m_pend));
`ifdef ETH_TX_SCHED_STATS_EN
        chk("arp_tx_cnt", 64'(arp_tx_cnt), 64'(m_arp_tx));
        chk("udp_tx_cnt", 64'(udp_tx_cnt), 64'(m_udp_tx));
        chk("arp_drop_cnt", 64'(arp_drop_cnt), 64'(m_drop));
        chk("abort_cnt", 64'(abort_cnt), 64'(m_abn));
`endif
        if (tx_start === 1'b1) begin
            obs_q.push_back(tx_sel);
            last_mac  = tx_mac_d_addr;
            start_obs = cyc;
        end
        if (tx_abort === 1'b1) begin
            n_abort_obs++;
            abort_gap = cyc - start_obs;
        end
        d_arp = 0;
    endtask

    task automatic do_reset();
        d_rst = 1; d_udp = 0;
        step();
        d_rst = 0;
        obs_q.delete();
        n_abort_obs = 0;
    endtask

    initial begin
        d_rst = 1; d_arp = 0; d_udp = 0; d_mac = '0; rnd_len = 0; spur = 0; next_len = 5;
        areset = 1; arp_req = 0; arp_req_mac = '0; udp_req = 0; tx_done = 0;
        m_start = -100; m_last = -100; m_idle = 0; m_abort = -100; m_done = -100;
        start_obs = 0; abort_gap = 0; n_abort_obs = 0; last_mac = '0;
        repeat (3) step();
        d_rst = 0;
        step();

        // single ARP, 60-cycle frame
        next_len = 60;
        d_arp = 1; d_mac = 48'h001122334455;
        step();
        repeat (90) step();
        chk("arp1_frames", 64'(obs_q.size()), 64'(1));
        chk("arp1_mac", 64'(last_mac), 64'h001122334455);

        // fairness: udp held high, ARP re-requested at every frame start
        do_reset();
        next_len = 3;
        d_arp = 1; d_mac = 48'hA0A0A0A0A0A0;
        step();
        d_udp = 1;
        repeat (300) begin
            if (cyc == m_start) begin
                d_arp = 1;
                d_mac = {16'($urandom), $urandom};
            end
            step();
        end
        d_udp = 0;
        chk("fair_count", 64'(obs_q.size() >= 10), 64'(1));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fair_%0d", i), 64'(obs_q[i]), 64'(pat[i]));
        end
        repeat (20) step();

        // two ARP requests during a UDP frame: only the second is answered
        do_reset();
        next_len = 20;
        d_udp = 1; step(); d_udp = 0;
        repeat (3) step();
        d_arp = 1; d_mac = 48'h0000000000AA; step();
        step();
        d_arp = 1; d_mac = 48'h0000000000BB; step();
        repeat (60) step();
        chk("ovw_frames", 64'(obs_q.size()), 64'(2));
        chk("ovw_sel", 64'(obs_q[1]), 64'(1));
        chk("ovw_mac", 64'(last_mac), 64'h0000000000BB);
`ifdef ETH_TX_SCHED_STATS_EN
        chk("ovw_drop", 64'(arp_drop_cnt), 64'(1));
`endif

        // hung builder: abort, IFG, then the pending ARP goes out
        do_reset();
        next_len = 0;
        d_udp = 1; step(); d_udp = 0;
        repeat (5) step();
        d_arp = 1; d_mac = 48'h0000000000CC; step();
        next_len = 4;
        repeat (TO + 40) step();
        chk("to_aborts", 64'(n_abort_obs), 64'(1));
        chk("to_gap", 64'(abort_gap), 64'(TO + 1));
        chk("to_frames", 64'(obs_q.size()), 64'(2));
        chk("to_mac", 64'(last_mac), 64'h0000000000CC);

        // arp_req in the grant cycle; tx_done on the last timeout cycle
        do_reset();
        next_len = TO;
        d_arp = 1; d_mac = 48'h0000000000D1; step();
        d_arp = 1; d_mac = 48'h0000000000D2; step();
        chk("simul_pend", 64'(arp_pending), 64'(1));
        chk("simul_mac1", 64'(tx_mac_d_addr), 64'h0000000000D1);
        repeat (200) step();
        chk("simul_noabort", 64'(n_abort_obs), 64'(0));
        chk("simul_frames", 64'(obs_q.size()), 64'(2));
        chk("simul_mac2", 64'(last_mac), 64'h0000000000D2);

        // reset while BUSY with an ARP pending
        do_reset();
        next_len = 30;
        d_udp = 1; step(); d_udp = 0;
        repeat (5) step();
        d_arp = 1; d_mac = 48'h0000000000EE; step();
        step();
        d_rst = 1; step(); d_rst = 0;
        chk("rst_pend", 64'(arp_pending), 64'(0));
        chk("rst_busy", 64'(tx_busy), 64'(0));
        obs_q.delete();
        repeat (60) step();
        chk("rst_nostart", 64'(obs_q.size()), 64'(0));

        // random traffic with spurious tx_done outside BUSY and rare resets
        rnd_len = 1; spur = 1;
        repeat (4000) begin
            d_arp = ($urandom_range(0, 11) == 0);
            d_mac = {16'($urandom), $urandom};
            if ($urandom_range(0, 15) == 0) d_udp = ~d_udp;
            d_rst = ($urandom_range(0, 999) == 0);
            step();
        end
        d_rst = 0; d_udp = 0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
